// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Receive side of the serial link. Reassembles MSB-first
//               frames from the serial_in/enable/start stream into
//               DATA_WIDTH-bit words. Completed words are held in a
//               one-entry output register with a valid/ready handshake, so
//               the next frame can assemble while the consumer stalls.
//               Truncated frames, stray bits and output overflow are
//               reported as one-cycle error pulses.
//
// Ports       : clk           - clock, all logic on the rising edge
//               rst_n         - synchronous active-low reset
//               serial_in     - serial data bit, valid when enable=1
//               enable        - serial_in carries a bit this cycle
//               start         - marks the MSB of a frame (with enable=1)
//               parallel_out  - received word, stable while out_valid=1
//               out_valid     - parallel_out holds an unconsumed word
//               out_ready     - consumer accepts on out_valid && out_ready
//               busy          - a frame is partially assembled
//               err_truncated - pulse: partial frame aborted by a new start
//               err_stray     - pulse: bit without start while idle
//               err_overflow  - pulse: completed word dropped, output full
//
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  enable,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err_truncated,
    output logic                  err_stray,
    output logic                  err_overflow
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] c_last_idx = COUNTER_WIDTH'(DATA_WIDTH - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_one      = COUNTER_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [DATA_WIDTH-1:0]    w_shift_nxt;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_nxt;

    logic [DATA_WIDTH-1:0]    r_parallel;
    logic                     r_valid;
    logic                     r_err_trunc;
    logic                     r_err_stray;
    logic                     r_err_ovf;

    logic [DATA_WIDTH-1:0]    w_word;
    logic                     w_complete;
    logic                     w_trunc;
    logic                     w_stray;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_ovf;

    // Word as it stands once the current bit is shifted in.
    assign w_word = {r_shift[DATA_WIDTH-2:0], serial_in};

    // ------------------------------------------------------------------------
    // Frame assembly: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_complete  = 1'b0;
        w_trunc     = 1'b0;
        w_stray     = 1'b0;

        // Cycles with enable=0 are gaps: everything holds.
        if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_shift_nxt = w_word;
                        w_count_nxt = c_one;
                        w_state_nxt = ST_RECV;
                    end else begin
                        w_stray = 1'b1;
                    end
                end
                ST_RECV: begin
                    w_shift_nxt = w_word;
                    if (start) begin
                        // A new MSB restarts the frame; the partial word is lost.
                        w_trunc     = 1'b1;
                        w_count_nxt = c_one;
                    end else if (r_count == c_last_idx) begin
                        w_complete  = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_count_nxt = r_count + c_one;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register control. A completing word may replace a word that is
    // being accepted on the same edge, which keeps back-to-back frames free
    // of bubbles.
    // ------------------------------------------------------------------------
    assign w_accept = r_valid && out_ready;
    assign w_load   = w_complete && (!r_valid || out_ready);
    assign w_ovf    = w_complete && r_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_parallel  <= '0;
            r_valid     <= 1'b0;
            r_err_trunc <= 1'b0;
            r_err_stray <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_count     <= w_count_nxt;
            r_err_trunc <= w_trunc;
            r_err_stray <= w_stray;
            r_err_ovf   <= w_ovf;

            if (w_load) begin
                r_parallel <= w_word;
                r_valid    <= 1'b1;
            end else if (w_accept) begin
                r_valid    <= 1'b0;
            end
        end
    end

    assign parallel_out  = r_parallel;
    assign out_valid     = r_valid;
    assign busy          = (r_state == ST_RECV);
    assign err_truncated = r_err_trunc;
    assign err_stray     = r_err_stray;
    assign err_overflow  = r_err_ovf;

endmodule
`default_nettype wire

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive side of the team's serial link; reconstructs parallel words from the `serial_out`/`enable`/`start` stream produced by the serializer.
- Bits arrive MSB first, one per cycle in which `enable` is high; `start` marks the MSB of each frame.
- Completed words go to a one-entry output register with a valid/ready handshake, so the next frame can assemble while the consumer stalls.
- Truncated frames, stray bits and output overflow are flagged.

Parameters:
- DATA_WIDTH, 8, bits per frame and width of parallel_out (>=2).
- COUNTER_WIDTH, $clog2(DATA_WIDTH)+1, derived, bit counter width; not overridden.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- serial_in  input  1  serial data bit, valid when enable=1.
- enable  input  1  serial_in carries a bit this cycle.
- start  input  1  first (MSB) bit of a frame; only meaningful with enable=1.
- parallel_out  output  DATA_WIDTH  received word, stable while out_valid=1.
- out_valid  output  1  parallel_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- busy  output  1  a frame is partially assembled.
- err_truncated  output  1  one-cycle pulse: frame aborted by a new start.
- err_stray  output  1  one-cycle pulse: enable without start while idle (bit discarded).
- err_overflow  output  1  one-cycle pulse: completed frame dropped because output register full.

Behaviour:
- Reset (rst_n=0 at clock edge): parallel_out=0, out_valid=0, busy=0, all err_* =0, shift register=0, bit counter=0.
- Reset mid-frame or with out_valid=1 discards everything; no pulses.
- States: IDLE (busy=0) and RECV (busy=1).
- Input sampling happens only on cycles with enable=1. Cycles with enable=0 are gaps: no state change, counter held. Gaps inside a frame are legal.
- start=1 with enable=0 is ignored.
- IDLE, enable=1, start=1: shift register <= {.., serial_in}, counter <= 1, go to RECV.
- IDLE, enable=1, start=0: bit dropped, err_stray=1 next cycle, stay IDLE.
- RECV, enable=1, start=0:
  - Shift left, inserting serial_in at the LSB; counter+1.
  - When this is bit DATA_WIDTH (counter==DATA_WIDTH-1 before the edge), the word {shift[DATA_WIDTH-2:0], serial_in} completes.
  - After completion: go to IDLE, counter <= 0.
- RECV, enable=1, start=1: current partial frame discarded, err_truncated=1 next cycle. The bit is treated as the MSB of a new frame (counter <= 1, stay RECV).
- DATA_WIDTH=... edge case: if DATA_WIDTH bits have arrived, no truncation is possible; completion always precedes the next start.
- Word completion at edge k:
  - If out_valid=0, or out_valid && out_ready at edge k: parallel_out <= word, out_valid=1 after edge k. This gives zero-bubble back-to-back frames.
  - Else: word dropped, err_overflow=1 after edge k, parallel_out and out_valid unchanged.
- Latency: out_valid rises the cycle after the edge that samples the LSB, i.e. DATA_WIDTH cycles after the start edge with no gaps.
- Handshake:
  - out_valid && out_ready with no completion at that edge: out_valid <= 0, parallel_out holds its last value.
  - parallel_out must not change while out_valid=1 && out_ready=0.
  - out_ready may be high while out_valid=0; this has no effect.
- Back-to-back serializer frames (start immediately after the last bit) must be received with no lost bits.
- err_* are registered, high exactly one cycle per event. Several may assert in the same cycle only if their events coincide.

Test Plan:
- Single frame (DATA_WIDTH=8): start+enable with bits of 0xA5 MSB first, out_ready=1 → out_valid high one cycle, 8 cycles after the start edge, parallel_out=0xA5, no err.
- Gaps: frame 0x3C with enable=0 inserted after bits 2 and 5 → parallel_out=0x3C, busy high throughout, out_valid 2 cycles later than the no-gap case.
- Truncation: 4 bits of 0xFF, then start with frame 0x12 → err_truncated one pulse at the restart, output 0x12 only.
- Overflow/backpressure: out_ready=0, frames 0x11 then 0x22 → parallel_out=0x11 held, err_overflow pulse on the 0x22 completion. Then out_ready=1 → 0x11 accepted, out_valid falls.
- Simultaneous accept: out_valid=1 (0x55), out_ready=1 on the edge completing 0x66 → out_valid stays 1, parallel_out=0x66, no err_overflow.
- Stray and reset: enable=1 with start=0 while idle → err_stray pulse, no output. Then reset after 3 bits of a frame → all outputs 0; next full frame 0x81 is received correctly.
